mul_rr_sched: RTL
=================

Name: mul_rr_sched

Overview:
- Shares one iterative repeated-addition 8x8 multiplier between N_REQ requesters.
- Round-robin arbitration, one operation in flight at a time.
- Latches the winner's operands, sequences the add/decrement iterations, and returns a tagged 16-bit product with a one-cycle done pulse.
- Sits between the requesting datapath blocks and the shared multiplier resource.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 8, operand width; product width is 2*W.
- ID_W, 2, requester index width; must equal clog2(N_REQ).

Ports:
- clk  in  1  rising-edge system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester request level; held until matching gnt
- a_in  in  N_REQ*W  packed multiplicands; requester i at [i*W +: W]
- b_in  in  N_REQ*W  packed multipliers (iteration count); requester i at [i*W +: W]
- gnt  out  N_REQ  one-hot one-cycle pulse; operands captured
- busy  out  1  high from grant until done
- done  out  1  one-cycle pulse; result valid
- done_id  out  ID_W  index of requester owning result
- result  out  2*W  product; held until next done

Behaviour:
- Reset (async, rst_n=0): state=IDLE; gnt=0, busy=0, done=0, done_id=0, result=0; acc/a/cnt=0; rr pointer=0 (requester 0 highest priority).
- FSM states: IDLE, RUN, DONE. Encoding is in the package.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner by round-robin: search starts at ptr, wraps modulo N_REQ, first set bit wins.
  - At that edge: latch a=a_in[win], cnt=b_in[win], acc=0, id=win; gnt[win]=1 for exactly the next cycle; busy=1; go to RUN.
- RUN, each edge:
  - cnt!=0: acc=acc+a (2*W-bit, zero-extended a); cnt=cnt-1.
  - cnt==0: result=acc; done=1 for one cycle; done_id=id; busy=0; ptr=(id+1) mod N_REQ; go to DONE.
- DONE: one cycle, then IDLE. The next grant is possible at the edge leaving IDLE, so there is one idle cycle between operations.
- Latency: done is asserted b+1 edges after the grant edge (b=0 gives 1 edge, result 0). Total occupancy is b+3 cycles per operation.
- Arithmetic: max product (2^W-1)^2 fits in 2*W bits, so no overflow or saturation. a=0 still iterates b times, with no early exit.
- Requester rules:
  - Operands are sampled only at the grant edge; later changes to a_in/b_in are ignored.
  - A requester must drop req the cycle after its gnt, or it re-enters arbitration.
  - Dropping req during RUN does not abort the operation; the result is still delivered.
- Simultaneous requests: exactly one gnt bit, chosen by ptr. Losers keep req asserted and wait.
- Fairness: any continuously asserted req is granted within N_REQ operations.
- New req during RUN/DONE: queued implicitly (level-sensitive) and arbitrated in the next IDLE.
- Reset mid-operation: the in-flight product is discarded, no done is issued, and all outputs return to reset values immediately.
- Reset release: no grant on the first edge unless req is set at that edge.

Decomposition:
- Package mul_sched_pkg:
  - state typedef (IDLE/RUN/DONE)
  - W and N_REQ defaults
  - product width constant 2*W
- Sub-module mul_iter_core:
  - Function: repeated-addition engine with acc, a, cnt registers.
  - Ports: clk, rst_n, start, a, b, done, product.
  - Top level keeps the arbiter, rr pointer, FSM and id tagging.

Test Plan:
- Single op: req=0001, a0=7, b0=5 -> gnt=0001 one cycle; done 6 edges after grant edge; result=35, done_id=0.
- Zero/extreme: b0=0, a0=200 -> done after 1 edge, result=0. Then a0=255, b0=255 -> result=65025 after 256 edges.
- Contention: req=1111 held, all a=i+1, b=2 -> grant order 0,1,2,3,0; results 2,4,6,8, each with matching done_id.
- Fairness after skip: ptr=2 with req=0011 -> grant 0 then 1; the pointer wraps correctly.
- Operand change: change a_in/b_in and drop req during RUN -> result uses values latched at grant; done still pulses.
- Async reset: assert rst_n=0 mid-RUN between clock edges -> busy=0, result=0, gnt=0 immediately; no done after release; the next req is served from ptr=0.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared types and default sizes for the round-robin scheduled iterative multiplier.
package mul_sched_pkg;

   localparam int W_DEF     = 8;
   localparam int N_REQ_DEF = 4;
   localparam int PROD_W    = 2 * W_DEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mul_iter_core.sv
// Repeated-addition multiply engine: loads on start, adds a once per edge until cnt reaches zero.
module mul_iter_core
   import mul_sched_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           done,
   output logic [2*W-1:0] product
);

   logic [2*W-1:0] acc_q, acc_d;
   logic [W-1:0]   a_q;
   logic [W-1:0]   cnt_q, cnt_d;
   logic           run_q, run_d;

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      run_d = run_q;
      if (run_q) begin
         if (cnt_q != '0) begin
            acc_d = acc_q + {{W{1'b0}}, a_q};
            cnt_d = cnt_q - 1'b1;
         end else begin
            run_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         a_q   <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start) begin
         acc_q <= '0;
         a_q   <= a;
         cnt_q <= b;
         run_q <= 1'b1;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   // Combinational so the owner can capture the product on the same edge the engine stops.
   assign done    = run_q && (cnt_q == '0);
   assign product = acc_q;

endmodule

// File: rtl/mul_rr_sched.sv
// Round-robin arbiter sharing one iterative multiplier; returns a tagged product with a done pulse.
module mul_rr_sched
   import mul_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W     = W_DEF,
   parameter int ID_W  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] a_in,
   input  logic [N_REQ*W-1:0] b_in,
   output logic [N_REQ-1:0]   gnt,
   output logic               busy,
   output logic               done,
   output logic [ID_W-1:0]    done_id,
   output logic [2*W-1:0]     result
);

   state_t              state_q;
   logic [ID_W-1:0]     ptr_q;
   logic [ID_W-1:0]     id_q;
   logic [N_REQ-1:0]    gnt_q;
   logic                busy_q;
   logic                done_q;
   logic [ID_W-1:0]     done_id_q;
   logic [2*W-1:0]      result_q;

   logic [W-1:0]        a_arr [N_REQ];
   logic [W-1:0]        b_arr [N_REQ];
   logic                win_valid;
   logic [ID_W-1:0]     win_id;
   logic                core_start;
   logic                core_done;
   logic [2*W-1:0]      core_product;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = a_in[gi*W +: W];
      assign b_arr[gi] = b_in[gi*W +: W];
   end

   // Walk from the highest offset down so the requester nearest ptr overwrites the others.
   always_comb begin
      logic [ID_W-1:0] idx;
      win_valid = 1'b0;
      win_id    = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = ID_W'((int'(ptr_q) + k) % N_REQ);
         if (req[idx]) begin
            win_valid = 1'b1;
            win_id    = idx;
         end
      end
   end

   assign core_start = (state_q == ST_IDLE) && win_valid;

   mul_iter_core #(.W(W)) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (core_start),
      .a       (a_arr[win_id]),
      .b       (b_arr[win_id]),
      .done    (core_done),
      .product (core_product)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         id_q      <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         result_q  <= '0;
      end else begin
         gnt_q  <= '0;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (win_valid) begin
                  gnt_q   <= N_REQ'(1) << win_id;
                  id_q    <= win_id;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (core_done) begin
                  result_q  <= core_product;
                  done_q    <= 1'b1;
                  done_id_q <= id_q;
                  busy_q    <= 1'b0;
                  ptr_q     <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                  state_q   <= ST_DONE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign done_id = done_id_q;
   assign result  = result_q;

endmodule
